spi_txn_scheduler: RTL and testbench
====================================

# spi_txn_scheduler

Shares the single `Master_Slave` SPI master among `NREQ` requesters and sequences each transaction for it. Arbitrates round-robin, drives the master's `mode`, `reset`, `sendOrder`, `ssi` and `address` inputs with the required pulse widths, and inserts a master reset whenever the SPI mode changes. It waits a fixed transfer time, then returns the master's `sensor` byte to the winning requester. It sits between client logic and `Master_Slave`.

## Interface
- `NREQ`, default 3: number of requesters.
- `ORDER_CYCLES`, default 2: cycles `m_sendOrder` is held high.
- `XFER_CYCLES`, default 16: cycles from `m_sendOrder` falling until `m_sensor` is valid.
- `MRST_CYCLES`, default 2: cycles `m_reset` is held high on a mode change.
- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `req`, input, NREQ: request level; held until `ack`/`err`.
- `req_ssi`, input, 2*NREQ: slave select per requester (01/10/11 valid, 00 invalid).
- `req_addr`, input, 8*NREQ: register address per requester.
- `req_mode`, input, 2*NREQ: SPI mode per requester.
- `gnt`, output, NREQ: one-hot grant, held for the whole transaction.
- `ack`, output, NREQ: one-cycle completion pulse.
- `err`, output, NREQ: one-cycle pulse on an invalid `ssi`.
- `rdata`, output, 8: captured sensor byte; valid with `ack`, held until the next capture.
- `busy`, output, 1: high whenever state is not IDLE.
- `m_reset`, `m_sendOrder`, output, 1: master reset and start.
- `m_mode`, `m_ssi`, output, 2: master mode and slave select.
- `m_address`, output, 8: master address.
- `m_sensor`, input, 8: master read data.

## Operation
- Reset values:
  - `m_reset`=1; all other outputs 0.
  - `cur_mode`=00; round-robin pointer=0; state=IDLE.
- First cycle after reset release: `m_reset`=0.
- State IDLE:
  - If any `req` is high, pick the first requester at or after the pointer, wrapping modulo NREQ.
  - Register `gnt`, `m_ssi`, `m_address` and the requested mode.
- Transitions out of IDLE:
  - `ssi`==00 → ERR.
  - Requested mode != `cur_mode` → MRST.
  - Otherwise → ISSUE.
- State MRST: `m_reset`=1 and `m_mode`=new mode for MRST_CYCLES; update `cur_mode`; → ISSUE.
- State ISSUE: `m_sendOrder`=1 for ORDER_CYCLES; → WAIT.
- State WAIT: count XFER_CYCLES; → CAPTURE.
- State CAPTURE:
  - `rdata`<=`m_sensor`; pulse `ack[i]`.
  - Pointer <= i+1 mod NREQ; clear `gnt`; → IDLE.
- State ERR: pulse `err[i]` for 1 cycle; no master activity; advance pointer; → IDLE.
- `m_ssi`, `m_address` and `m_mode` are stable from grant through CAPTURE, and keep their values in IDLE.
- `req` dropped mid-transaction: ignored; the transaction completes and `ack` still pulses.
- New requests during `busy`: not sampled until IDLE.
- Reset mid-transaction:
  - Abort immediately, return to reset values.
  - No `ack` for the aborted transaction.
  - Master gets `m_reset`=1.

## Timing
- Arbitration decision is registered; `gnt` rises 1 cycle after `req` is seen in IDLE.
- Same-mode latency, `req` sampled to `ack`: 1 + ORDER_CYCLES + XFER_CYCLES + 1 = 20 cycles at defaults.
- Mode-change latency: + MRST_CYCLES = 22 cycles.
- `rdata` updates on the same edge that raises `ack`.
- Back-to-back: IDLE occupies at least 1 cycle between transactions, so `m_sendOrder` has ≥ XFER_CYCLES+2 low cycles between pulses.
- ERR path: `err` pulses 2 cycles after `req` is sampled.

## Structure
- Shared package `spi_pkg`:
  - State enum (IDLE, MRST, ISSUE, WAIT, CAPTURE, ERR).
  - SSI constants SSI_NONE=00, SSI_S1=01, SSI_S2=10, SSI_S3=11.
  - Mode width constant 2.
- Sub-module `rr_arbiter` (NREQ-wide, pointer in, one-hot grant out): combinational.
- Counter and FSM stay in the top module.

## Test plan
- Single request: requester 0, ssi=01, addr=03, mode=00, stub `m_sensor`=8'h13. Required:
  - No MRST.
  - `m_sendOrder` high exactly 2 cycles.
  - `ack[0]` 20 cycles after req, with `rdata`=8'h13.
- Mode change: requester 1, mode=01, ssi=11, addr=08. Required:
  - `m_reset` high 2 cycles with `m_mode`=01 before `m_sendOrder`.
  - `ack[1]` at 22 cycles.
- Round-robin: all three `req` high from reset. Required:
  - Grants in order 0,1,2, then 0 again.
  - Each `gnt` one-hot and non-overlapping.
- Invalid select: requester 2, ssi=00. Required:
  - `err[2]` pulse, no `ack`.
  - `m_sendOrder`, `m_reset` never rise.
  - Pointer advances to 0.
- Abort: assert `reset` during WAIT. Required:
  - All outputs at reset values next sample; `m_reset`=1.
  - No `ack`.
  - A fresh request afterwards completes normally.
- Request drop: deassert `req[0]` during ISSUE. Required:
  - The transaction still completes.
  - `ack[0]` pulses with the captured byte.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI transaction scheduler.
package spi_pkg;

  localparam int unsigned MODE_W = 2;
  localparam int unsigned SSI_W  = 2;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;

  localparam logic [SSI_W-1:0] SSI_NONE = 2'b00;
  localparam logic [SSI_W-1:0] SSI_S1   = 2'b01;
  localparam logic [SSI_W-1:0] SSI_S2   = 2'b10;
  localparam logic [SSI_W-1:0] SSI_S3   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MRST,
    ST_ISSUE,
    ST_WAIT,
    ST_CAPTURE,
    ST_ERR
  } state_e;

  // Master-facing request fields; mode doubles as the master's current mode.
  typedef struct packed {
    logic [MODE_W-1:0] mode;
    logic [SSI_W-1:0]  ssi;
    logic [ADDR_W-1:0] addr;
  } txn_t;

  function automatic logic ssi_valid(input logic [SSI_W-1:0] ssi);
    return ssi != SSI_NONE;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request at or after the pointer.
module rr_arbiter #(
  parameter int unsigned NREQ  = 3,
  parameter int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [NREQ-1:0]  gnt_c,
  output logic [PTR_W-1:0] idx_c
);

  logic             found;
  logic [PTR_W-1:0] cand;

  always_comb begin
    gnt_c = '0;
    idx_c = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = PTR_W'((32'(ptr_i) + k) % NREQ);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_c[cand] = 1'b1;
        idx_c       = cand;
      end
    end
  end

endmodule

// File: rtl/spi_txn_scheduler.sv
// Shares one Master_Slave SPI master among NREQ requesters: arbitrates,
// sequences mode-change reset / order pulse / transfer wait, returns the byte.
module spi_txn_scheduler
  import spi_pkg::*;
#(
  parameter int unsigned NREQ         = 3,
  parameter int unsigned ORDER_CYCLES = 2,
  parameter int unsigned XFER_CYCLES  = 16,
  parameter int unsigned MRST_CYCLES  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [SSI_W*NREQ-1:0]  req_ssi,
  input  logic [ADDR_W*NREQ-1:0] req_addr,
  input  logic [MODE_W*NREQ-1:0] req_mode,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        ack,
  output logic [NREQ-1:0]        err,
  output logic [DATA_W-1:0]      rdata,
  output logic                   busy,
  output logic                   m_reset,
  output logic                   m_sendOrder,
  output logic [MODE_W-1:0]      m_mode,
  output logic [SSI_W-1:0]       m_ssi,
  output logic [ADDR_W-1:0]      m_address,
  input  logic [DATA_W-1:0]      m_sensor
);

  localparam int unsigned PTR_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned MAX_A   = (ORDER_CYCLES > XFER_CYCLES) ? ORDER_CYCLES : XFER_CYCLES;
  localparam int unsigned CNT_MAX = (MRST_CYCLES > MAX_A) ? MRST_CYCLES : MAX_A;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] ORDER_LD = CNT_W'(ORDER_CYCLES - 1);
  localparam logic [CNT_W-1:0] XFER_LD  = CNT_W'(XFER_CYCLES - 1);
  localparam logic [CNT_W-1:0] MRST_LD  = CNT_W'(MRST_CYCLES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   idx_q, idx_d;
  txn_t               mbus_q, mbus_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic [NREQ-1:0]    ack_q, ack_d;
  logic [NREQ-1:0]    err_q, err_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               busy_q, busy_d;
  logic               m_reset_q, m_reset_d;
  logic               m_send_q, m_send_d;

  logic [NREQ-1:0]    arb_gnt_c;
  logic [PTR_W-1:0]   arb_idx_c;
  logic [PTR_W-1:0]   ptr_next_c;
  txn_t               sel_c;

  logic [SSI_W-1:0]   ssi_arr  [NREQ];
  logic [ADDR_W-1:0]  addr_arr [NREQ];
  logic [MODE_W-1:0]  mode_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign ssi_arr[g]  = req_ssi[g*SSI_W +: SSI_W];
    assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
    assign mode_arr[g] = req_mode[g*MODE_W +: MODE_W];
  end

  rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_c (arb_gnt_c),
    .idx_c (arb_idx_c)
  );

  always_comb begin
    sel_c.mode = mode_arr[arb_idx_c];
    sel_c.ssi  = ssi_arr[arb_idx_c];
    sel_c.addr = addr_arr[arb_idx_c];
  end

  assign ptr_next_c = (idx_q == PTR_W'(NREQ - 1)) ? '0 : idx_q + PTR_W'(1);

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    mbus_d    = mbus_q;
    gnt_d     = gnt_q;
    ack_d     = '0;
    err_d     = '0;
    rdata_d   = rdata_q;
    m_reset_d = 1'b0;
    m_send_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          gnt_d       = arb_gnt_c;
          idx_d       = arb_idx_c;
          mbus_d.ssi  = sel_c.ssi;
          mbus_d.addr = sel_c.addr;
          if (!ssi_valid(sel_c.ssi)) begin
            state_d = ST_ERR;
          end else if (sel_c.mode != mbus_q.mode) begin
            state_d     = ST_MRST;
            mbus_d.mode = sel_c.mode;
            m_reset_d   = 1'b1;
            cnt_d       = MRST_LD;
          end else begin
            state_d  = ST_ISSUE;
            m_send_d = 1'b1;
            cnt_d    = ORDER_LD;
          end
        end
      end
      ST_MRST: begin
        if (cnt_q == '0) begin
          state_d  = ST_ISSUE;
          m_send_d = 1'b1;
          cnt_d    = ORDER_LD;
        end else begin
          m_reset_d = 1'b1;
          cnt_d     = cnt_q - CNT_W'(1);
        end
      end
      ST_ISSUE: begin
        if (cnt_q == '0) begin
          state_d = ST_WAIT;
          cnt_d   = XFER_LD;
        end else begin
          m_send_d = 1'b1;
          cnt_d    = cnt_q - CNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_CAPTURE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_CAPTURE: begin
        rdata_d = m_sensor;
        ack_d   = gnt_q;
        gnt_d   = '0;
        ptr_d   = ptr_next_c;
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        err_d   = gnt_q;
        gnt_d   = '0;
        ptr_d   = ptr_next_c;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // Reset leaves the master held in reset until the first clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ptr_q     <= '0;
      idx_q     <= '0;
      mbus_q    <= '0;
      gnt_q     <= '0;
      ack_q     <= '0;
      err_q     <= '0;
      rdata_q   <= '0;
      busy_q    <= 1'b0;
      m_reset_q <= 1'b1;
      m_send_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      mbus_q    <= mbus_d;
      gnt_q     <= gnt_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      busy_q    <= busy_d;
      m_reset_q <= m_reset_d;
      m_send_q  <= m_send_d;
    end
  end

  assign gnt         = gnt_q;
  assign ack         = ack_q;
  assign err         = err_q;
  assign rdata       = rdata_q;
  assign busy        = busy_q;
  assign m_reset     = m_reset_q;
  assign m_sendOrder = m_send_q;
  assign m_mode      = mbus_q.mode;
  assign m_ssi       = mbus_q.ssi;
  assign m_address   = mbus_q.addr;

endmodule

// File: tb/tb_spi_txn_scheduler.sv
// Scoreboard bench for spi_txn_scheduler: directed scenarios plus randomized
// concurrent requests, expected results from a transaction-level model.
module tb_spi_txn_scheduler;
  import spi_pkg::*;

  localparam int NREQ  = 3;
  localparam int ORDER = 2;
  localparam int XFER  = 16;
  localparam int MRST  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [2*NREQ-1:0] req_ssi;
  logic [8*NREQ-1:0] req_addr;
  logic [2*NREQ-1:0] req_mode;
  logic [NREQ-1:0]   gnt, ack, err;
  logic [7:0]        rdata;
  logic              busy, m_reset, m_sendOrder;
  logic [1:0]        m_mode, m_ssi;
  logic [7:0]        m_address, m_sensor;

  spi_txn_scheduler #(
    .NREQ(NREQ), .ORDER_CYCLES(ORDER), .XFER_CYCLES(XFER), .MRST_CYCLES(MRST)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_ssi(req_ssi), .req_addr(req_addr),
    .req_mode(req_mode), .gnt(gnt), .ack(ack), .err(err), .rdata(rdata), .busy(busy),
    .m_reset(m_reset), .m_sendOrder(m_sendOrder), .m_mode(m_mode), .m_ssi(m_ssi),
    .m_address(m_address), .m_sensor(m_sensor)
  );

  always #5 clk = ~clk;

  // Stub master: read data is a function of the selected slave and address.
  assign m_sensor = m_address + 8'({m_ssi, 4'h0});

  typedef struct {
    int         idx;
    bit         is_err;
    bit         mrst;
    logic [7:0] rdata;
    logic [1:0] ssi;
    logic [7:0] addr;
    logic [1:0] mode;
  } exp_t;

  exp_t       sbq[$];
  int         n_cmp = 0;
  int         n_fail = 0;
  int         model_ptr = 0;
  logic [1:0] model_mode = 2'b00;
  logic [1:0] r_ssi  [NREQ];
  logic [7:0] r_addr [NREQ];
  logic [1:0] r_mode [NREQ];

  task automatic check(input string name, input longint got, input longint expv);
    n_cmp++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, expv, $time);
    end
  endtask

  function automatic int exp_gnt_lat(input exp_t e);
    if (e.is_err) return 1;
    return ORDER + XFER + 1 + (e.mrst ? MRST : 0);
  endfunction

  // Transaction-level model: one granted request advances the pointer and mode.
  function automatic void model_push(input int i);
    exp_t e;
    e.idx    = i;
    e.ssi    = r_ssi[i];
    e.addr   = r_addr[i];
    e.is_err = (r_ssi[i] == 2'b00);
    e.mrst   = !e.is_err && (r_mode[i] != model_mode);
    if (e.mrst) model_mode = r_mode[i];
    e.mode   = model_mode;
    e.rdata  = 8'(r_addr[i] + {r_ssi[i], 4'h0});
    model_ptr = (i + 1) % NREQ;
    sbq.push_back(e);
  endfunction

  function automatic int model_pick(input logic [NREQ-1:0] pend);
    for (int k = 0; k < NREQ; k++)
      if (pend[(model_ptr + k) % NREQ]) return (model_ptr + k) % NREQ;
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [1:0] ssi, input logic [7:0] addr,
                         input logic [1:0] mode);
    r_ssi[i] = ssi; r_addr[i] = addr; r_mode[i] = mode;
    req_ssi[i*2 +: 2]  = ssi;
    req_addr[i*8 +: 8] = addr;
    req_mode[i*2 +: 2] = mode;
  endtask

  task automatic issue_set(input logic [NREQ-1:0] mask);
    logic [NREQ-1:0] pend;
    int i;
    pend = mask;
    while (pend != 0) begin
      i = model_pick(pend);
      model_push(i);
      pend[i] = 1'b0;
    end
    req = req | mask;
  endtask

  task automatic serve(input logic [NREQ-1:0] mask);
    logic [NREQ-1:0] left;
    int n;
    left = mask;
    n = 0;
    while (left != 0 && n < 100 * NREQ) begin
      @(negedge clk);
      n++;
      for (int i = 0; i < NREQ; i++)
        if (left[i] && (ack[i] || err[i])) begin
          left[i] = 1'b0;
          req[i]  = 1'b0;
        end
    end
    check("serve_done", left, 0);
  endtask

  // Single request with req-to-done latency check; drop_at>0 drops req early.
  task automatic single(input int i, input logic [1:0] ssi, input logic [7:0] addr,
                        input logic [1:0] mode, input int drop_at);
    exp_t e;
    int n;
    set_req(i, ssi, addr, mode);
    issue_set(NREQ'(1) << i);
    e = sbq[sbq.size()-1];
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == 1) check("busy_after_grant", busy, 1);
      if (n == drop_at) req[i] = 1'b0;
      if (ack[i] || err[i]) break;
    end
    req[i] = 1'b0;
    check("req_to_done_latency", n, exp_gnt_lat(e) + 1);
  endtask

  task automatic check_reset_vals();
    check("rst_m_reset", m_reset, 1);
    check("rst_m_sendOrder", m_sendOrder, 0);
    check("rst_gnt", gnt, 0);
    check("rst_ack", ack, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_rdata", rdata, 0);
    check("rst_m_mode", m_mode, 0);
    check("rst_m_ssi", m_ssi, 0);
    check("rst_m_address", m_address, 0);
  endtask

  // Monitor: follows each grant on the master bus and scores its completion.
  int              cyc = 0;
  bit              in_txn = 1'b0;
  int              g_cyc, so_cnt, mr_cnt;
  logic [1:0]      so_mode, mr_mode;
  logic [NREQ-1:0] g_val;
  bit              g_held;
  exp_t            mon_e;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      in_txn = 1'b0;
    end else begin
      if (!in_txn && gnt != 0) begin
        in_txn = 1'b1; g_cyc = cyc; so_cnt = 0; mr_cnt = 0;
        so_mode = 2'b00; mr_mode = 2'b00; g_val = gnt; g_held = 1'b1;
        check("gnt_onehot", $onehot(gnt), 1);
        if (sbq.size() > 0) check("gnt_order", gnt, NREQ'(1) << sbq[0].idx);
      end
      if (in_txn) begin
        if (gnt != 0 && gnt != g_val) g_held = 1'b0;
        if (m_sendOrder) begin so_cnt++; so_mode = m_mode; end
        if (m_reset) begin mr_cnt++; mr_mode = m_mode; end
      end
      if ((ack | err) != 0) begin
        if (sbq.size() == 0 || !in_txn) begin
          check("unexpected_done", {ack, err}, 0);
        end else begin
          mon_e = sbq.pop_front();
          check("done_latency", cyc - g_cyc, exp_gnt_lat(mon_e));
          check("gnt_held", g_held, 1);
          check("mrst_cycles", mr_cnt, mon_e.mrst ? MRST : 0);
          if (mon_e.is_err) begin
            check("err_vec", err, NREQ'(1) << mon_e.idx);
            check("ack_on_err", ack, 0);
            check("order_on_err", so_cnt, 0);
          end else begin
            check("ack_vec", ack, NREQ'(1) << mon_e.idx);
            check("err_on_ack", err, 0);
            check("rdata", rdata, mon_e.rdata);
            check("order_cycles", so_cnt, ORDER);
            check("mode_at_order", so_mode, mon_e.mode);
            check("m_ssi_held", m_ssi, mon_e.ssi);
            check("m_address_held", m_address, mon_e.addr);
            if (mon_e.mrst) check("mode_during_mrst", mr_mode, mon_e.mode);
          end
        end
        in_txn = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NREQ-1:0] mask;
    reset = 1'b1; req = '0; req_ssi = '0; req_addr = '0; req_mode = '0;
    for (int i = 0; i < NREQ; i++) set_req(i, 2'b00, 8'h00, 2'b00);
    repeat (3) @(negedge clk);
    check_reset_vals();

    // All three requesting out of reset: grants 0,1,2.
    set_req(0, 2'b01, 8'h21, 2'b00);
    set_req(1, 2'b10, 8'h42, 2'b00);
    set_req(2, 2'b11, 8'h63, 2'b00);
    issue_set(3'b111);
    reset = 1'b0;
    @(negedge clk);
    check("m_reset_after_release", m_reset, 0);
    serve(3'b111);

    // Back round to 0; same mode, so no master reset.
    single(0, 2'b01, 8'h03, 2'b00, 0);
    // Mode change on requester 1.
    single(1, 2'b11, 8'h08, 2'b01, 0);
    // Invalid select on requester 2, then 1 and 2 together: pointer now at 0.
    single(2, 2'b00, 8'h55, 2'b10, 0);
    set_req(1, 2'b01, 8'h11, 2'b01);
    set_req(2, 2'b10, 8'h22, 2'b01);
    issue_set(3'b110);
    serve(3'b110);
    // Request withdrawn during ISSUE still completes.
    single(0, 2'b01, 8'h77, 2'b01, 2);

    // Abort during WAIT.
    set_req(0, 2'b10, 8'h99, 2'b01);
    req[0] = 1'b1;
    repeat (8) @(negedge clk);
    reset = 1'b1;
    #2;
    check_reset_vals();
    req[0] = 1'b0;
    model_ptr = 0;
    model_mode = 2'b00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check("idle_after_abort", busy, 0);
    single(1, 2'b10, 8'h5A, 2'b00, 0);

    // Randomized concurrent request sets.
    for (int r = 0; r < 40; r++) begin
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++)
        if (mask[i])
          set_req(i, ($urandom_range(0, 7) == 0) ? 2'b00 : 2'($urandom_range(1, 3)),
                  8'($urandom), 2'($urandom_range(0, 3)));
      issue_set(mask);
      serve(mask);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
